// File: rtl/sa_tile_core.sv
// Output-stationary ROWS x COLS systolic tile. It sequences itself through
// IDLE/COMPUTE/DRAIN/OUTPUT, skews its operands internally and can accumulate across tiles.
module sa_tile_core #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int INWIDTH  = 8,
  parameter int OUTWIDTH = 32,
  parameter int KMAX     = 256,
  parameter int SIGNED   = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [$clog2(KMAX+1)-1:0]    cfg_k,
  input  logic                         cfg_acc,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*INWIDTH-1:0]      a_in,
  input  logic [COLS*INWIDTH-1:0]      w_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS*OUTWIDTH-1:0]     out_row,
  output logic [$clog2(ROWS)-1:0]      out_row_idx,
  output logic                         out_last,
  output logic                         busy
);

  localparam int KW  = $clog2(KMAX + 1);
  localparam int IW  = $clog2(ROWS);
  localparam int DW  = $clog2(ROWS + COLS);
  localparam int PW  = 2 * INWIDTH;
  localparam int ASK = (ROWS > 1) ? ROWS - 1 : 1;
  localparam int WSK = (COLS > 1) ? COLS - 1 : 1;

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DRAIN, S_OUTPUT} state_t;

  function automatic logic [KW-1:0] clamp_k(input logic [KW-1:0] k);
    if (k == '0) return KW'(1);
    if (k > KW'(KMAX)) return KW'(KMAX);
    return k;
  endfunction

  // Full-precision product extended to the accumulator width; accumulation wraps.
  function automatic logic [OUTWIDTH-1:0] mac_product(input logic [INWIDTH-1:0] a,
                                                      input logic [INWIDTH-1:0] w);
    logic signed [PW-1:0] a_x, w_x, p;
    logic                 ext_a, ext_w, ext_p;
    ext_a = (SIGNED != 0) && a[INWIDTH-1];
    ext_w = (SIGNED != 0) && w[INWIDTH-1];
    a_x   = {{INWIDTH{ext_a}}, a};
    w_x   = {{INWIDTH{ext_w}}, w};
    p     = a_x * w_x;
    ext_p = (SIGNED != 0) && p[PW-1];
    return {{(OUTWIDTH-PW){ext_p}}, p};
  endfunction

  state_t          state_q, state_d;
  logic [KW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [KW-1:0]   keff_q, keff_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [IW-1:0]   row_idx_q, row_idx_d;
  logic [KW-1:0]   keff_new;
  logic            accept, advance, out_fire, tile_clear;

  logic [INWIDTH-1:0]  a_new [ROWS];
  logic [INWIDTH-1:0]  w_new [COLS];
  logic [INWIDTH-1:0]  a_sk_q [ROWS][ASK], a_sk_d [ROWS][ASK];
  logic                av_sk_q [ROWS][ASK], av_sk_d [ROWS][ASK];
  logic [INWIDTH-1:0]  w_sk_q [COLS][WSK], w_sk_d [COLS][WSK];
  logic                wv_sk_q [COLS][WSK], wv_sk_d [COLS][WSK];
  logic [INWIDTH-1:0]  a_pe_q [ROWS][COLS], a_pe_d [ROWS][COLS];
  logic                av_pe_q [ROWS][COLS], av_pe_d [ROWS][COLS];
  logic [INWIDTH-1:0]  w_pe_q [ROWS][COLS], w_pe_d [ROWS][COLS];
  logic                wv_pe_q [ROWS][COLS], wv_pe_d [ROWS][COLS];
  logic [OUTWIDTH-1:0] acc_q [ROWS][COLS], acc_d [ROWS][COLS];

  assign keff_new   = clamp_k(cfg_k);
  assign accept     = in_valid && in_ready;
  assign advance    = accept || (state_q == S_DRAIN);
  assign out_fire   = out_valid && out_ready;
  assign tile_clear = (state_q == S_IDLE) && accept && !cfg_acc;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = (keff_new == KW'(1)) ? S_DRAIN : S_COMPUTE;
      S_COMPUTE: if (accept && (beat_cnt_q == keff_q - KW'(1))) state_d = S_DRAIN;
      S_DRAIN:   if (drain_cnt_q == DW'(ROWS + COLS - 2)) state_d = S_OUTPUT;
      S_OUTPUT:  if (out_fire && out_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready    = rstn && ((state_q == S_IDLE) || (state_q == S_COMPUTE));
    out_valid   = rstn && (state_q == S_OUTPUT);
    busy        = rstn && (state_q != S_IDLE);
    out_row_idx = rstn ? row_idx_q : '0;
    out_last    = out_valid && (row_idx_q == IW'(ROWS - 1));
    for (int c = 0; c < COLS; c++)
      out_row[c*OUTWIDTH +: OUTWIDTH] = out_valid ? acc_q[row_idx_q][c] : '0;
  end

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    keff_d      = keff_q;
    drain_cnt_d = '0;
    row_idx_d   = row_idx_q;
    case (state_q)
      S_IDLE: begin
        row_idx_d = '0;
        if (accept) begin
          keff_d     = keff_new;
          beat_cnt_d = KW'(1);
        end
      end
      S_COMPUTE: if (accept) beat_cnt_d = beat_cnt_q + KW'(1);
      S_DRAIN:   drain_cnt_d = drain_cnt_q + DW'(1);
      S_OUTPUT:  if (out_fire) row_idx_d = out_last ? '0 : row_idx_q + IW'(1);
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt_q  <= '0;
      keff_q      <= '0;
      drain_cnt_q <= '0;
      row_idx_q   <= '0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      keff_q      <= keff_d;
      drain_cnt_q <= drain_cnt_d;
      row_idx_q   <= row_idx_d;
    end
  end

  // Operand entry: drain cycles feed zero, invalid slots into the array.
  always_comb begin
    for (int r = 0; r < ROWS; r++) a_new[r] = accept ? a_in[r*INWIDTH +: INWIDTH] : '0;
    for (int c = 0; c < COLS; c++) w_new[c] = accept ? w_in[c*INWIDTH +: INWIDTH] : '0;
  end

  // Skew chains and PE array advance together; a stalled COMPUTE cycle freezes everything.
  always_comb begin
    a_sk_d  = a_sk_q;
    av_sk_d = av_sk_q;
    w_sk_d  = w_sk_q;
    wv_sk_d = wv_sk_q;
    a_pe_d  = a_pe_q;
    av_pe_d = av_pe_q;
    w_pe_d  = w_pe_q;
    wv_pe_d = wv_pe_q;
    acc_d   = acc_q;
    if (advance) begin
      for (int r = 0; r < ROWS; r++) begin
        a_sk_d[r][0]  = a_new[r];
        av_sk_d[r][0] = accept;
        for (int s = 1; s < ASK; s++) begin
          a_sk_d[r][s]  = a_sk_q[r][s-1];
          av_sk_d[r][s] = av_sk_q[r][s-1];
        end
        a_pe_d[r][0]  = (r == 0) ? a_new[r] : a_sk_q[r][(r == 0) ? 0 : r - 1];
        av_pe_d[r][0] = (r == 0) ? accept   : av_sk_q[r][(r == 0) ? 0 : r - 1];
        for (int c = 1; c < COLS; c++) begin
          a_pe_d[r][c]  = a_pe_q[r][c-1];
          av_pe_d[r][c] = av_pe_q[r][c-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        w_sk_d[c][0]  = w_new[c];
        wv_sk_d[c][0] = accept;
        for (int s = 1; s < WSK; s++) begin
          w_sk_d[c][s]  = w_sk_q[c][s-1];
          wv_sk_d[c][s] = wv_sk_q[c][s-1];
        end
        w_pe_d[0][c]  = (c == 0) ? w_new[c] : w_sk_q[c][(c == 0) ? 0 : c - 1];
        wv_pe_d[0][c] = (c == 0) ? accept   : wv_sk_q[c][(c == 0) ? 0 : c - 1];
        for (int r = 1; r < ROWS; r++) begin
          w_pe_d[r][c]  = w_pe_q[r-1][c];
          wv_pe_d[r][c] = wv_pe_q[r-1][c];
        end
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (av_pe_q[r][c] && wv_pe_q[r][c])
            acc_d[r][c] = acc_q[r][c] + mac_product(a_pe_q[r][c], w_pe_q[r][c]);
    end
    if (tile_clear) acc_d = '{default: '0};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      a_sk_q  <= '{default: '0};
      av_sk_q <= '{default: '0};
      w_sk_q  <= '{default: '0};
      wv_sk_q <= '{default: '0};
      a_pe_q  <= '{default: '0};
      av_pe_q <= '{default: '0};
      w_pe_q  <= '{default: '0};
      wv_pe_q <= '{default: '0};
      acc_q   <= '{default: '0};
    end else begin
      a_sk_q  <= a_sk_d;
      av_sk_q <= av_sk_d;
      w_sk_q  <= w_sk_d;
      wv_sk_q <= wv_sk_d;
      a_pe_q  <= a_pe_d;
      av_pe_q <= av_pe_d;
      w_pe_q  <= w_pe_d;
      wv_pe_q <= wv_pe_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_sa_tile_core.sv
// Scoreboard bench for sa_tile_core: a matrix-level reference model fills the expected
// queue per tile, and an independent monitor checks every output beat and handshake rule.
module tb_sa_tile_core;
  localparam int ROWS = 4, COLS = 4, INW = 8, OUTW = 32, KMAX = 256;
  localparam int KW = $clog2(KMAX + 1);
  localparam int IW = $clog2(ROWS);

  logic                   clk = 1'b0;
  logic                   rstn;
  logic [KW-1:0]          cfg_k;
  logic                   cfg_acc, in_valid, in_ready;
  logic [ROWS*INW-1:0]    a_in;
  logic [COLS*INW-1:0]    w_in;
  logic                   out_valid, out_ready, out_last, busy;
  logic [COLS*OUTW-1:0]   out_row;
  logic [IW-1:0]          out_row_idx;

  sa_tile_core #(.ROWS(ROWS), .COLS(COLS), .INWIDTH(INW), .OUTWIDTH(OUTW),
                 .KMAX(KMAX), .SIGNED(1)) dut (
    .clk(clk), .rstn(rstn), .cfg_k(cfg_k), .cfg_acc(cfg_acc),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .w_in(w_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [COLS*OUTW-1:0] row;
    logic [IW-1:0]        idx;
    logic                 last;
  } beat_t;

  beat_t       sb[$];
  int          ta [KMAX][ROWS];
  int          tw [KMAX][COLS];
  logic [OUTW-1:0] m_acc [ROWS][COLS];
  int          wrows [4][4] = '{'{5, -3, 0, 7}, '{1, 2, 3, 4}, '{-128, 127, 0, 1}, '{9, 9, 9, 9}};
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, last_acc_cyc = 0;
  bit          draining = 0;
  int          sink_mode = 0, stall_n = 0;

  bit              mon_prev_ov = 0, mon_hold = 0;
  logic [127:0]    h_row;
  logic [IW-1:0]   h_idx;
  logic            h_last;
  beat_t           mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_acc[r][c] = '0;
  endtask

  // C = (acc ? C_prev : 0) + A*W, wrapping at OUTW bits.
  task automatic model_tile(input int keff, input bit acc);
    beat_t e;
    if (!acc) model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int k = 0; k < keff; k++)
          m_acc[r][c] = m_acc[r][c] + 32'(ta[k][r] * tw[k][c]);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) e.row[c*OUTW +: OUTW] = m_acc[r][c];
      e.idx  = IW'(r);
      e.last = (r == ROWS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic fill_rand(input int n);
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < ROWS; r++) ta[k][r] = int'($urandom_range(255, 0)) - 128;
      for (int c = 0; c < COLS; c++) tw[k][c] = int'($urandom_range(255, 0)) - 128;
    end
  endtask

  task automatic fill_const(input int n, input int av, input int wv);
    for (int k = 0; k < n; k++) begin
      for (int r = 0; r < ROWS; r++) ta[k][r] = av;
      for (int c = 0; c < COLS; c++) tw[k][c] = wv;
    end
  endtask

  // Called aligned to posedge+1; returns aligned the same way.
  task automatic run_tile(input int kcfg, input bit acc, input int gap_lo, input int gap_hi,
                          input int abort_at);
    int keff, g, t;
    bit ok;
    keff = (kcfg < 1) ? 1 : ((kcfg > KMAX) ? KMAX : kcfg);
    for (int b = 0; b < keff; b++) begin
      g = int'($urandom_range(gap_hi, gap_lo));
      repeat (g) begin
        in_valid = 1'b0;
        a_in = (ROWS*INW)'($urandom); w_in = (COLS*INW)'($urandom);
        cfg_k = KW'($urandom); cfg_acc = 1'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      for (int r = 0; r < ROWS; r++) a_in[r*INW +: INW] = INW'(ta[b][r]);
      for (int c = 0; c < COLS; c++) w_in[c*INW +: INW] = INW'(tw[b][c]);
      if (b == 0) begin
        cfg_k = KW'(kcfg); cfg_acc = acc;
      end else begin
        cfg_k = KW'($urandom); cfg_acc = 1'($urandom);
      end
      ok = 0; t = 0;
      while (!ok && t < 100) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; last_acc_cyc = cyc; end
        @(posedge clk); #1;
        t++;
      end
      chk("beat_accept", 128'(ok), 128'(1));
      if (abort_at == b) begin
        in_valid = 1'b0; rstn = 1'b0;
        @(negedge clk);
        chk("abort_rst_out_valid", 128'(out_valid), 128'(0));
        chk("abort_rst_busy", 128'(busy), 128'(0));
        chk("abort_rst_in_ready", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        model_clear();
        return;
      end
    end
    model_tile(keff, acc);
    draining = 1;
    t = 0;
    while (t < 600) begin
      if (sb.size() == 0 && !out_valid) break;
      a_in = (ROWS*INW)'($urandom); w_in = (COLS*INW)'($urandom);
      cfg_k = KW'($urandom); cfg_acc = 1'($urandom);
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    draining = 0;
    chk("tile_drained", 128'(sb.size()), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_in_ready", 128'(in_ready), 128'(1));
  endtask

  // Output sink
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (sink_mode)
        1: out_ready = ($urandom_range(2, 0) != 0);
        2: if (out_valid && out_row_idx == IW'(1) && stall_n < 5) begin
             out_ready = 1'b0; stall_n++;
           end else out_ready = 1'b1;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        mon_prev_ov = 0; mon_hold = 0;
        continue;
      end
      if (mon_hold) begin
        chk("hold_out_valid", 128'(out_valid), 128'(1));
        chk("hold_out_row", out_row, h_row);
        chk("hold_out_row_idx", 128'(out_row_idx), 128'(h_idx));
        chk("hold_out_last", 128'(out_last), 128'(h_last));
      end
      mon_hold = 0;
      if (out_valid) begin
        chk("in_ready_output", 128'(in_ready), 128'(0));
        draining = 0;
        if (!mon_prev_ov) chk("latency", 128'(cyc - last_acc_cyc), 128'(ROWS + COLS));
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 128'(out_valid), 128'(0));
        end else if (out_ready) begin
          mon_e = sb.pop_front();
          chk("out_row", out_row, mon_e.row);
          chk("out_row_idx", 128'(out_row_idx), 128'(mon_e.idx));
          chk("out_last", 128'(out_last), 128'(mon_e.last));
        end else begin
          mon_hold = 1; h_row = out_row; h_idx = out_row_idx; h_last = out_last;
        end
      end else if (draining) begin
        chk("in_ready_drain", 128'(in_ready), 128'(0));
      end
      mon_prev_ov = out_valid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; cfg_k = '0; cfg_acc = 1'b0; a_in = '0; w_in = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_row", out_row, 128'(0));
    chk("rst_out_row_idx", 128'(out_row_idx), 128'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // K=1 broadcast
    for (int r = 0; r < ROWS; r++) ta[0][r] = r + 1;
    for (int c = 0; c < COLS; c++) tw[0][c] = 1;
    run_tile(1, 0, 0, 0, -1);

    // identity A reproduces W, with and without input gaps
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < ROWS; r++) ta[k][r] = (r == k) ? 1 : 0;
      for (int c = 0; c < COLS; c++) tw[k][c] = wrows[k][c];
    end
    run_tile(4, 0, 0, 0, -1);
    run_tile(4, 0, 3, 3, -1);

    // output backpressure on row 1
    sink_mode = 2; stall_n = 0;
    fill_rand(4);
    run_tile(4, 1, 0, 1, -1);
    sink_mode = 0;

    // most-negative operands and accumulate-across-tiles
    fill_const(4, -128, -128);
    run_tile(4, 0, 0, 0, -1);
    run_tile(4, 1, 0, 0, -1);
    run_tile(4, 0, 0, 0, -1);

    // abort by reset, then accumulate onto cleared state
    fill_rand(4);
    run_tile(4, 0, 0, 0, 2);
    repeat (20) @(posedge clk);
    #1;
    fill_const(1, 2, 2);
    run_tile(1, 1, 0, 0, -1);
    fill_rand(1);
    run_tile(0, 0, 0, 0, -1);

    // randomized tiles under random backpressure
    sink_mode = 1;
    for (int i = 0; i < 8; i++) begin
      int k;
      bit acc;
      k = int'($urandom_range(10, 1));
      acc = 1'($urandom);
      fill_rand(k);
      run_tile(k, acc, 0, 2, -1);
    end
    fill_rand(KMAX);
    run_tile(300, 1, 0, 0, -1);
    sink_mode = 0;

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
